player_controller: RTL and testbench

//  Upstream of the main datapath's player registers. Owns player_pos_x/y and player_angle.
//  On each start pulse it applies one frame of key input: rotate, step along the heading, and collision-check against the grid.

---
 rtl/player_controller_pkg.sv | 38 +++
 rtl/player_controller_trig_lut.sv | 36 +++
 rtl/player_controller.sv | 146 ++++++++++++++
 tb/tb_player_controller.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/player_controller_pkg.sv
// Shared geometry, widths and FSM encodings for the player pose controller.
package player_controller_pkg;

  localparam int CELL_SHIFT = 8;
  localparam int GRID_W     = 64;
  localparam int GRID_H     = 32;
  localparam int GX_W       = $clog2(GRID_W);
  localparam int GY_W       = $clog2(GRID_H);
  localparam int POS_X_W    = CELL_SHIFT + GX_W;
  localparam int POS_Y_W    = CELL_SHIFT + GY_W;
  localparam int ANG_W      = 8;
  localparam int CAND_W     = 16;
  localparam int TRIG_W     = 9;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_TURN = 3'd1;
  localparam logic [2:0] ST_STEP = 3'd2;
  localparam logic [2:0] ST_RD_X = 3'd3;
  localparam logic [2:0] ST_CK_X = 3'd4;
  localparam logic [2:0] ST_RD_Y = 3'd5;
  localparam logic [2:0] ST_CK_Y = 3'd6;
  localparam logic [2:0] ST_DONE = 3'd7;

  // Opposing key pairs are already cancelled when this is captured.
  typedef struct packed {
    logic cw;
    logic ccw;
    logic fwd;
    logic back;
  } keys_t;

  function automatic logic out_of_bounds(input logic signed [CAND_W-1:0] v, input int w);
    int vi;
    vi = int'(v);
    return (vi < 0) || (vi >= (1 << w));
  endfunction

endpackage

// File: rtl/player_controller_trig_lut.sv
// Combinational sin/cos for an 8-bit heading, signed result scaled by 128.
module trig_lut
  import player_controller_pkg::*;
(
  input  logic [ANG_W-1:0]         i_angle,
  output logic signed [TRIG_W-1:0] o_sin,
  output logic signed [TRIG_W-1:0] o_cos
);

  // round(128*sin(k*pi/128)), first quadrant only.
  localparam logic [7:0] TAB [64] = '{
    8'd0,   8'd3,   8'd6,   8'd9,   8'd13,  8'd16,  8'd19,  8'd22,
    8'd25,  8'd28,  8'd31,  8'd34,  8'd37,  8'd40,  8'd43,  8'd46,
    8'd49,  8'd52,  8'd55,  8'd58,  8'd60,  8'd63,  8'd66,  8'd68,
    8'd71,  8'd74,  8'd76,  8'd79,  8'd81,  8'd84,  8'd86,  8'd88,
    8'd91,  8'd93,  8'd95,  8'd97,  8'd99,  8'd101, 8'd103, 8'd105,
    8'd106, 8'd108, 8'd110, 8'd111, 8'd113, 8'd114, 8'd116, 8'd117,
    8'd118, 8'd119, 8'd121, 8'd122, 8'd122, 8'd123, 8'd124, 8'd125,
    8'd126, 8'd126, 8'd127, 8'd127, 8'd127, 8'd128, 8'd128, 8'd128
  };

  // Odd quadrants mirror the table; index 0 there is the peak, which the table lacks.
  function automatic logic signed [TRIG_W-1:0] sin9(input logic [ANG_W-1:0] a);
    logic [5:0]        idx;
    logic [TRIG_W-1:0] mag;
    idx = a[5:0];
    if (!a[6])              mag = {1'b0, TAB[idx]};
    else if (idx == 6'd0)   mag = 9'd128;
    else                    mag = {1'b0, TAB[6'd0 - idx]};
    return a[7] ? -$signed(mag) : $signed(mag);
  endfunction

  assign o_sin = sin9(i_angle);
  assign o_cos = sin9(i_angle + 8'd64);

endmodule

// File: rtl/player_controller.sv
// Per-frame player pose update: rotate, step along heading, per-axis wall check
// through a registered grid port so the player slides along walls.
module player_controller
  import player_controller_pkg::*;
#(
  parameter int SPEED    = 32,
  parameter int ROT_STEP = 4,
  parameter int SPAWN_X  = 384,
  parameter int SPAWN_Y  = 384
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         reset_player,
  input  logic         start,
  input  logic         key_fwd,
  input  logic         key_back,
  input  logic         key_left,
  input  logic         key_right,
  output logic [5:0]   grid_x,
  output logic [4:0]   grid_y,
  input  logic [2:0]   grid_out,
  output logic [13:0]  pos_x,
  output logic [12:0]  pos_y,
  output logic [7:0]   angle,
  output logic         busy,
  output logic         done
);

  logic [2:0]           r_state;
  keys_t                r_keys;
  logic [POS_X_W-1:0]   r_pos_x;
  logic [POS_Y_W-1:0]   r_pos_y;
  logic [ANG_W-1:0]     r_angle;
  logic [POS_X_W-1:0]   r_cand_x;
  logic [POS_Y_W-1:0]   r_cand_y;
  logic                 r_rej_x;
  logic                 r_rej_y;
  logic [GX_W-1:0]      r_grid_x;
  logic [GY_W-1:0]      r_grid_y;

  logic signed [TRIG_W-1:0] w_sin, w_cos;
  logic signed [31:0]       w_mx, w_my;
  logic signed [CAND_W-1:0] w_dx, w_dy, w_px, w_py, w_cand_x, w_cand_y;
  logic [ANG_W-1:0]         w_ang_nxt;
  logic [POS_X_W-1:0]       w_pos_x_nxt;
  logic                     w_rej_x, w_rej_y;

  trig_lut u_trig (
    .i_angle (r_angle),
    .o_sin   (w_sin),
    .o_cos   (w_cos)
  );

  assign w_ang_nxt = r_keys.cw  ? r_angle + ANG_W'(ROT_STEP) :
                     r_keys.ccw ? r_angle - ANG_W'(ROT_STEP) : r_angle;

  // Step vector from the already-rotated heading.
  assign w_mx = 32'(w_cos) * SPEED;
  assign w_my = 32'(w_sin) * SPEED;
  assign w_dx = CAND_W'(w_mx >>> 7);
  assign w_dy = CAND_W'(w_my >>> 7);

  assign w_px = $signed({{(CAND_W-POS_X_W){1'b0}}, r_pos_x});
  assign w_py = $signed({{(CAND_W-POS_Y_W){1'b0}}, r_pos_y});

  assign w_cand_x = r_keys.fwd ? w_px + w_dx : r_keys.back ? w_px - w_dx : w_px;
  assign w_cand_y = r_keys.fwd ? w_py + w_dy : r_keys.back ? w_py - w_dy : w_py;

  assign w_rej_x = out_of_bounds(w_cand_x, POS_X_W);
  assign w_rej_y = out_of_bounds(w_cand_y, POS_Y_W);

  // The y lookup must see the x result of this same frame.
  assign w_pos_x_nxt = (!r_rej_x && grid_out == '0) ? r_cand_x : r_pos_x;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_keys   <= '0;
      r_pos_x  <= '0;
      r_pos_y  <= '0;
      r_angle  <= '0;
      r_cand_x <= '0;
      r_cand_y <= '0;
      r_rej_x  <= 1'b0;
      r_rej_y  <= 1'b0;
      r_grid_x <= '0;
      r_grid_y <= '0;
    end else if (reset_player) begin
      r_state <= ST_IDLE;
      r_pos_x <= POS_X_W'(SPAWN_X);
      r_pos_y <= POS_Y_W'(SPAWN_Y);
      r_angle <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_keys.cw   <= key_right & ~key_left;
          r_keys.ccw  <= key_left  & ~key_right;
          r_keys.fwd  <= key_fwd   & ~key_back;
          r_keys.back <= key_back  & ~key_fwd;
          r_state     <= ST_TURN;
        end
        ST_TURN: begin
          r_angle <= w_ang_nxt;
          r_state <= ST_STEP;
        end
        ST_STEP: begin
          r_cand_x <= w_cand_x[POS_X_W-1:0];
          r_cand_y <= w_cand_y[POS_Y_W-1:0];
          r_rej_x  <= w_rej_x;
          r_rej_y  <= w_rej_y;
          // An out-of-range candidate would alias onto a real cell, so no lookup.
          if (!w_rej_x) begin
            r_grid_x <= w_cand_x[CELL_SHIFT +: GX_W];
            r_grid_y <= r_pos_y[CELL_SHIFT +: GY_W];
          end
          r_state <= ST_RD_X;
        end
        ST_RD_X: r_state <= ST_CK_X;
        ST_CK_X: begin
          r_pos_x <= w_pos_x_nxt;
          if (!r_rej_y) begin
            r_grid_x <= w_pos_x_nxt[CELL_SHIFT +: GX_W];
            r_grid_y <= r_cand_y[CELL_SHIFT +: GY_W];
          end
          r_state <= ST_RD_Y;
        end
        ST_RD_Y: r_state <= ST_CK_Y;
        ST_CK_Y: begin
          if (!r_rej_y && grid_out == '0) r_pos_y <= r_cand_y;
          r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grid_x = r_grid_x;
  assign grid_y = r_grid_y;
  assign pos_x  = r_pos_x;
  assign pos_y  = r_pos_y;
  assign angle  = r_angle;
  assign busy   = (r_state != ST_IDLE);
  assign done   = (r_state == ST_DONE);

endmodule

// File: tb/tb_player_controller.sv
// Scoreboard bench for player_controller: frames push expected pose, monitor checks on done.
module tb_player_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        reset_player = 1'b0, start = 1'b0;
  logic        key_fwd = 1'b0, key_back = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic [5:0]  grid_x;
  logic [4:0]  grid_y;
  logic [2:0]  grid_out;
  logic [13:0] pos_x;
  logic [12:0] pos_y;
  logic [7:0]  angle;
  logic        busy, done;

  typedef struct { int x; int y; int a; int cyc; } exp_t;
  exp_t q[$];

  int checks = 0, errors = 0;
  int cyc = 0, ndone = 0, cnt63 = 0;
  logic wall [0:63][0:31];

  player_controller dut (
    .clock(clock), .reset(reset), .reset_player(reset_player), .start(start),
    .key_fwd(key_fwd), .key_back(key_back), .key_left(key_left), .key_right(key_right),
    .grid_x(grid_x), .grid_y(grid_y), .grid_out(grid_out),
    .pos_x(pos_x), .pos_y(pos_y), .angle(angle), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Registered grid memory model and event counters.
  always @(posedge clock) begin
    cyc      <= cyc + 1;
    grid_out <= wall[grid_x][grid_y] ? 3'd5 : 3'd0;
    if (grid_x == 6'd63) cnt63 <= cnt63 + 1;
    if (reset && done)   ndone <= ndone + 1;
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, want);
    end
  endtask

  always @(negedge clock) begin
    if (reset && done) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done got done at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("done_pos_x", 32'(pos_x), e.x);
        check("done_pos_y", 32'(pos_y), e.y);
        check("done_angle", 32'(angle), e.a);
        check("done_latency", cyc - e.cyc, 7);
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (q.size() != 0 && n < 20) begin tick(); n++; end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL frame_timeout got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic frame(input logic f, b, l, r, input int ex, ey, ea);
    key_fwd = f; key_back = b; key_left = l; key_right = r; start = 1'b1;
    q.push_back('{ex, ey, ea, cyc});
    tick();
    start = 1'b0; key_fwd = 0; key_back = 0; key_left = 0; key_right = 0;
    wait_empty();
    tick();
  endtask

  task automatic respawn();
    reset_player = 1'b1; tick(); reset_player = 1'b0;
    check("spawn_x", 32'(pos_x), 384);
    check("spawn_y", 32'(pos_y), 384);
    check("spawn_angle", 32'(angle), 0);
  endtask

  initial begin
    int nd;
    for (int i = 0; i < 64; i++) for (int j = 0; j < 32; j++) wall[i][j] = 1'b0;

    // Power-on reset state.
    tick(); tick();
    check("rst_pos_x", 32'(pos_x), 0);
    check("rst_pos_y", 32'(pos_y), 0);
    check("rst_angle", 32'(angle), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_grid_x", 32'(grid_x), 0);
    check("rst_grid_y", 32'(grid_y), 0);
    reset = 1'b1; tick();

    // Spawn then a plain forward step on an empty grid.
    respawn();
    frame(1, 0, 0, 0, 416, 384, 0);

    // Wall at cell (2,1): head-on block, then diagonal slide.
    frame(1, 0, 0, 0, 448, 384, 0);
    frame(1, 0, 0, 0, 480, 384, 0);
    wall[2][1] = 1'b1;
    frame(1, 0, 0, 0, 480, 384, 0);
    for (int k = 1; k <= 8; k++) frame(0, 0, 0, 1, 480, 384, 4 * k);
    frame(1, 0, 0, 0, 502, 406, 32);
    frame(1, 0, 0, 0, 502, 428, 32);
    frame(1, 1, 0, 0, 502, 428, 32);

    // Rotation, including wrap below zero and cancelling keys.
    frame(0, 0, 1, 0, 502, 428, 28);
    frame(0, 0, 1, 1, 502, 428, 28);
    respawn();
    frame(0, 0, 1, 0, 384, 384, 252);
    frame(0, 0, 1, 1, 384, 384, 252);
    frame(0, 0, 0, 1, 384, 384, 0);

    // Walk back to x=0, then the negative candidate must be rejected without a lookup.
    wall[2][1] = 1'b0;
    for (int k = 1; k <= 12; k++) frame(0, 1, 0, 0, 384 - 32 * k, 384, 0);
    frame(0, 1, 0, 0, 0, 384, 0);
    check("no_read_x63", cnt63, 0);

    // A second start while busy is ignored.
    nd = ndone;
    start = 1'b1; q.push_back('{0, 384, 0, cyc});
    tick(); start = 1'b0;
    tick(); check("busy_mid_frame", 32'(busy), 1);
    start = 1'b1; tick(); start = 1'b0;
    wait_empty();
    repeat (10) tick();
    check("single_done", ndone - nd, 1);

    // reset_player beats a simultaneous start.
    nd = ndone;
    reset_player = 1'b1; start = 1'b1; key_fwd = 1'b1; tick();
    reset_player = 1'b0; start = 1'b0; key_fwd = 1'b0;
    check("rp_start_x", 32'(pos_x), 384);
    check("rp_start_y", 32'(pos_y), 384);
    check("rp_start_busy", 32'(busy), 0);
    repeat (10) tick();
    check("rp_start_no_done", ndone - nd, 0);

    // Async reset while in RD_X clears everything at once.
    key_fwd = 1'b1; start = 1'b1; q.push_back('{416, 384, 0, cyc});
    tick(); start = 1'b0; key_fwd = 1'b0;
    tick(); tick();
    check("pre_reset_busy", 32'(busy), 1);
    q.delete();
    nd = ndone;
    #1 reset = 1'b0; #1;
    check("midrst_pos_x", 32'(pos_x), 0);
    check("midrst_pos_y", 32'(pos_y), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_grid_x", 32'(grid_x), 0);
    check("midrst_grid_y", 32'(grid_y), 0);
    tick(); tick();
    reset = 1'b1;
    repeat (12) tick();
    check("post_reset_no_done", ndone - nd, 0);
    check("post_reset_busy", 32'(busy), 0);
    check("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
